// File: rtl/cell_mem_arbiter.sv
// Three-way arbiter for a single-port cell RAM: raster reads win outright, engine and host share by round-robin.
// Optional denied-cycle counter on stall_count is built only when CELL_ARB_STALL_STATS_EN is defined.
module cell_mem_arbiter #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ras_req,
    input  logic [ADDR_W-1:0] ras_addr,
    output logic              ras_gnt,
    output logic              ras_rvalid,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       stall_count
);

    localparam int unsigned TAG_W  = 3;   // one-hot read owner {ras, eng, host}
    localparam int unsigned STAT_W = 16;
    localparam int unsigned T_RAS  = 2;
    localparam int unsigned T_ENG  = 1;
    localparam int unsigned T_HOST = 0;

    logic              last_nr_q, last_nr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  rv_q, rv_d;

    // Grant decode: combinational, forced low during reset
    always_comb begin
        ras_gnt  = 1'b0;
        eng_gnt  = 1'b0;
        host_gnt = 1'b0;
        if (reset_n) begin
            if (ras_req) begin
                ras_gnt = 1'b1;
            end else if (eng_req && host_req) begin
                if (last_nr_q) begin
                    eng_gnt = 1'b1;
                end else begin
                    host_gnt = 1'b1;
                end
            end else if (eng_req) begin
                eng_gnt = 1'b1;
            end else if (host_req) begin
                host_gnt = 1'b1;
            end
        end
    end

    // Next-state: winner's command to the RAM, read-owner tags two stages deep
    always_comb begin
        last_nr_d   = last_nr_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        tag_d       = '0;
        rv_d        = tag_q;
        if (ras_gnt) begin
            mem_addr_d   = ras_addr;
            tag_d[T_RAS] = 1'b1;
        end else if (eng_gnt) begin
            last_nr_d    = 1'b0;
            mem_addr_d   = eng_addr;
            mem_we_d     = eng_we;
            mem_wdata_d  = eng_wdata;
            tag_d[T_ENG] = ~eng_we;
        end else if (host_gnt) begin
            last_nr_d     = 1'b1;
            mem_addr_d    = host_addr;
            mem_we_d      = host_we;
            mem_wdata_d   = host_wdata;
            tag_d[T_HOST] = ~host_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_nr_q   <= 1'b1;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            tag_q       <= '0;
            rv_q        <= '0;
        end else begin
            last_nr_q   <= last_nr_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            tag_q       <= tag_d;
            rv_q        <= rv_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_wdata   = mem_wdata_q;
    assign ras_rvalid  = rv_q[T_RAS];
    assign eng_rvalid  = rv_q[T_ENG];
    assign host_rvalid = rv_q[T_HOST];
    // RAM output lines up with the rvalid cycle, so it passes straight through
    assign rd_data     = mem_rdata;

`ifdef CELL_ARB_STALL_STATS_EN
    logic [STAT_W-1:0] stall_q, stall_d;
    logic              denied;

    // Saturating count of cycles in which any non-raster requester waited
    always_comb begin
        denied  = (eng_req & ~eng_gnt) | (host_req & ~host_gnt);
        stall_d = stall_q;
        if (denied && (stall_q != {STAT_W{1'b1}})) begin
            stall_d = stall_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Bench for cell_mem_arbiter: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a transaction-level model (grant rule, RAM contents, read-return queue).
module tb_cell_mem_arbiter;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          ras_req = 1'b0;
    logic [AW-1:0] ras_addr = '0;
    logic          ras_gnt, ras_rvalid;
    logic          eng_req = 1'b0, eng_we = 1'b0;
    logic [AW-1:0] eng_addr = '0;
    logic [DW-1:0] eng_wdata = '0;
    logic          eng_gnt, eng_rvalid;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_rvalid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [15:0]   stall_count;

    cell_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .ras_req(ras_req), .ras_addr(ras_addr), .ras_gnt(ras_gnt), .ras_rvalid(ras_rvalid),
        .eng_req(eng_req), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_gnt(eng_gnt), .eng_rvalid(eng_rvalid),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .rd_data(rd_data), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'(a) ^ 16'h5A5A;
    endfunction

    // Single-port RAM with 1-cycle read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    int errors = 0;
    int checks = 0;
    int mcyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, mcyc);
        end
    endtask

    // Reference model: who wins, what the RAM holds, and which reads return when
    typedef struct {
        int            due;
        int            own;   // 1 ras, 2 eng, 3 host
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] refm [DEPTH];
    rd_t           rq [$];
    bit            mvalid = 1'b0;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    bit            e_last;
    logic [15:0]   e_stall;
    int            win_last = 0;

    always @(negedge clk) begin : model
        int            own;
        int            win;
        logic [DW-1:0] od;
        own = 0;
        od  = '0;
        if (mvalid) begin
            chk("mem_we", 32'(mem_we), 32'(e_we));
            chk("mem_addr", 32'(mem_addr), 32'(e_addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
            if (rq.size() > 0 && rq[0].due == mcyc) begin
                own = rq[0].own;
                od  = rq[0].data;
                rq.delete(0);
            end
            chk("ras_rvalid", 32'(ras_rvalid), 32'(own == 1));
            chk("eng_rvalid", 32'(eng_rvalid), 32'(own == 2));
            chk("host_rvalid", 32'(host_rvalid), 32'(own == 3));
            if (own != 0) chk("rd_data", 32'(rd_data), 32'(od));
            chk("stall_count", 32'(stall_count), 32'(e_stall));
        end
        win = 0;
        if (reset_n) begin
            if (ras_req) win = 1;
            else if (eng_req && host_req) win = e_last ? 2 : 3;
            else if (eng_req) win = 2;
            else if (host_req) win = 3;
        end
        chk("ras_gnt", 32'(ras_gnt), 32'(win == 1));
        chk("eng_gnt", 32'(eng_gnt), 32'(win == 2));
        chk("host_gnt", 32'(host_gnt), 32'(win == 3));
        if (!reset_n) begin
            e_addr = '0; e_we = 1'b0; e_wd = '0; e_last = 1'b1; e_stall = '0;
            rq.delete();
            mvalid = 1'b1;
        end else begin
`ifdef CELL_ARB_STALL_STATS_EN
            if (((eng_req && win != 2) || (host_req && win != 3)) && e_stall != 16'hFFFF)
                e_stall = e_stall + 16'd1;
`endif
            e_we = 1'b0;
            case (win)
                1: begin
                    e_addr = ras_addr;
                    rq.push_back('{due: mcyc + 2, own: 1, data: refm[ras_addr]});
                end
                2: begin
                    e_addr = eng_addr; e_we = eng_we; e_wd = eng_wdata; e_last = 1'b0;
                    if (eng_we) refm[eng_addr] = eng_wdata;
                    else rq.push_back('{due: mcyc + 2, own: 2, data: refm[eng_addr]});
                end
                3: begin
                    e_addr = host_addr; e_we = host_we; e_wd = host_wdata; e_last = 1'b1;
                    if (host_we) refm[host_addr] = host_wdata;
                    else rq.push_back('{due: mcyc + 2, own: 3, data: refm[host_addr]});
                end
                default: ;
            endcase
        end
        win_last = win;
        mcyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n  = 1'b0;
        ras_req  = 1'b0;
        eng_req  = 1'b0;
        host_req = 1'b0;
        repeat (n) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            ram[i]  = init_word(i);
            refm[i] = init_word(i);
        end

        // Grants stay low under reset even with every request up
        reset_n = 1'b0; ras_req = 1'b1; eng_req = 1'b1; host_req = 1'b1;
        @(negedge clk);
        chk("rst_ras_gnt", 32'(ras_gnt), 32'd0);
        chk("rst_eng_gnt", 32'(eng_gnt), 32'd0);
        chk("rst_host_gnt", 32'(host_gnt), 32'd0);
        tick();
        do_reset(2);
        @(negedge clk);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        tick();

        // Raster priority
        ras_req = 1'b1; ras_addr = 13'h0010;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0020;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0030;
        @(negedge clk);
        chk("prio_ras_gnt", 32'(ras_gnt), 32'd1);
        chk("prio_eng_gnt", 32'(eng_gnt), 32'd0);
        chk("prio_host_gnt", 32'(host_gnt), 32'd0);
        tick();
        ras_req = 1'b0; eng_req = 1'b0; host_req = 1'b0;
        @(negedge clk);
        chk("prio_mem_addr", 32'(mem_addr), 32'h0010);
        chk("prio_mem_we", 32'(mem_we), 32'd0);
        tick();
        @(negedge clk);
        chk("prio_ras_rvalid", 32'(ras_rvalid), 32'd1);
        chk("prio_rd_data", 32'(rd_data), 32'h5A4A);
        tick();

        // Round-robin fairness from reset: E,H,E,H,E,H
        do_reset(2);
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0040;
        host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0080;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("fair_eng_gnt", 32'(eng_gnt), 32'(i % 2 == 0));
            chk("fair_host_gnt", 32'(host_gnt), 32'(i % 2 == 1));
            tick();
        end
        eng_req = 1'b0; host_req = 1'b0;
        repeat (3) tick();

        // Host write then engine read of the same word
        host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0100; host_wdata = 16'hBEEF;
        @(negedge clk);
        chk("wr_host_gnt", 32'(host_gnt), 32'd1);
        tick();
        host_req = 1'b0; host_we = 1'b0;
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0100;
        @(negedge clk);
        chk("wr_eng_gnt", 32'(eng_gnt), 32'd1);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0100);
        chk("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        eng_req = 1'b0;
        @(negedge clk);
        chk("wr_no_host_rvalid", 32'(host_rvalid), 32'd0);
        tick();
        @(negedge clk);
        chk("rd_eng_rvalid", 32'(eng_rvalid), 32'd1);
        chk("rd_data_beef", 32'(rd_data), 32'hBEEF);
        chk("rd_no_host_rvalid", 32'(host_rvalid), 32'd0);
        tick();

        // Reset right after an engine read grant
        eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0055;
        @(negedge clk);
        chk("mid_eng_gnt", 32'(eng_gnt), 32'd1);
        tick();
        eng_req = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        chk("mid_no_rvalid", 32'(eng_rvalid), 32'd0);
        chk("mid_mem_we", 32'(mem_we), 32'd0);
        tick();
        eng_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
        @(negedge clk);
        chk("mid_last_nr_eng", 32'(eng_gnt), 32'd1);
        tick();
        eng_req = 1'b0; host_req = 1'b0;
        repeat (3) tick();

        // Back-to-back raster reads
        for (int i = 0; i < 10; i++) begin
            ras_req  = (i < 8);
            ras_addr = AW'(i);
            @(negedge clk);
            if (i >= 2) begin
                chk("tp_ras_rvalid", 32'(ras_rvalid), 32'd1);
                chk("tp_rd_data", 32'(rd_data), 32'(init_word(i - 2)));
            end
            tick();
        end
        ras_req = 1'b0;
        @(negedge clk);
        chk("tp_rvalid_end", 32'(ras_rvalid), 32'd0);
        tick();

        // Stall statistics
        do_reset(2);
        ras_req = 1'b1; ras_addr = 13'h0007; eng_req = 1'b1; eng_we = 1'b0; eng_addr = 13'h0001;
        repeat (10) tick();
        ras_req = 1'b0; eng_req = 1'b0;
        @(negedge clk);
`ifdef CELL_ARB_STALL_STATS_EN
        chk("stall_10", 32'(stall_count), 32'd10);
        tick();
        do_reset(2);
        ras_req = 1'b1; eng_req = 1'b1;
        repeat (65534) tick();
        @(negedge clk);
        chk("stall_fffe", 32'(stall_count), 32'hFFFE);
        repeat (3) tick();
        ras_req = 1'b0; eng_req = 1'b0;
        @(negedge clk);
        chk("stall_sat", 32'(stall_count), 32'hFFFF);
        tick();
        @(negedge clk);
        chk("stall_hold", 32'(stall_count), 32'hFFFF);
`else
        chk("stall_off", 32'(stall_count), 32'd0);
`endif
        tick();

        // Randomized traffic obeying the hold-until-grant rule
        do_reset(2);
        repeat (3000) begin
            reset_n  = ($urandom % 200 != 0);
            ras_req  = ($urandom % 4 == 0);
            ras_addr = AW'($urandom % 64);
            if (eng_req && win_last != 2) begin
                if ($urandom % 8 == 0) eng_req = 1'b0;
            end else begin
                eng_req   = 1'($urandom % 2);
                eng_we    = 1'($urandom % 2);
                eng_addr  = AW'($urandom % 64);
                eng_wdata = DW'($urandom);
            end
            if (host_req && win_last != 3) begin
                if ($urandom % 8 == 0) host_req = 1'b0;
            end else begin
                host_req   = 1'($urandom % 2);
                host_we    = 1'($urandom % 2);
                host_addr  = AW'($urandom % 64);
                host_wdata = DW'($urandom);
            end
            tick();
        end
        reset_n = 1'b1; ras_req = 1'b0; eng_req = 1'b0; host_req = 1'b0;
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
